// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU op codes,
// ALU B-operand selects and FSM state encodings.
package control_fsm_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Shared with the ALU; R-type opcodes map directly onto the first three.
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_NAND   = 3'b010;
    localparam logic [2:0] ALU_PASS_A = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/control_fsm_mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory handshake; expired marks the
// cycle in which the count has reached WAIT_LIMIT (never when WAIT_LIMIT is 0).
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (WAIT_LIMIT > 0) && (count == LIMIT);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: decodes the IR opcode into datapath enables, mux
// selects and ALU op, and supervises the memory handshake with a timeout.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        wb_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        aluout_write,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_error,
    output logic [3:0]  state_dbg
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] opcode;
    logic       mem_state;
    logic       expired;
    logic       timeout;
    logic       unused_fields;

    assign opcode        = instr[15:12];
    assign unused_fields = ^instr[11:0];
    assign mem_state     = is_mem_state(state);
    assign timeout       = mem_state && !mem_ready && expired;

    // The count restarts whenever no stalled handshake is in progress.
    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!mem_state || mem_ready),
        .waiting (mem_state && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAND: state_next = S_EXEC_R;
                    OP_ADDI:                 state_next = S_EXEC_I;
                    OP_LW, OP_SW:            state_next = S_MEM_ADDR;
                    OP_BEQ:                  state_next = S_BRANCH;
                    OP_JMP:                  state_next = S_JUMP;
                    OP_HALT:                 state_next = S_HALT;
                    default:                 state_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
        if (timeout) state_next = S_HALT;
    end

    // Outputs are a decode of the state register, forced quiet while reset is held.
    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        wb_src       = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_REG;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;
        mem_error    = 1'b0;
        state_dbg    = '0;
        if (rst_n) begin
            state_dbg = state;
            mem_error = timeout;
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_ONE;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b    = SRC_B_IMM;
                    aluout_write = 1'b1;
                    illegal_op   = !is_legal_op(opcode);
                end
                S_EXEC_R: begin
                    alu_src_a    = 1'b1;
                    alu_op       = opcode[2:0];
                    aluout_write = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRC_B_IMM;
                    aluout_write = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_src    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 1'b1;
                    pc_write  = zero_flag;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Randomised instruction stream against a per-instruction cycle-sequence model,
// plus directed scenarios with literal expectations on the recorded outputs.
module tb_control_fsm;
    import control_fsm_pkg::*;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic        reg_write, wb_src, alu_src_a, aluout_write, halted, illegal_op, mem_error;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    control_fsm #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_src(wb_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .aluout_write(aluout_write), .halted(halted), .illegal_op(illegal_op),
        .mem_error(mem_error), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, wb_src, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       aluout_write, halted, illegal_op, mem_error;
        logic [3:0] state_dbg;
    } outs_t;

    typedef struct packed {
        logic  care;
        outs_t e;
    } item_t;

    item_t       exp_q[$];
    outs_t       hist[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    logic [15:0] cur_ir = '0;
    bit          after_reset = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle that has a queued expectation is recorded and, if it matters, compared.
    initial forever begin
        item_t it;
        outs_t a;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            a  = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, wb_src,
                  alu_src_a, alu_src_b, alu_op, aluout_write, halted, illegal_op, mem_error, state_dbg};
            hist.push_back(a);
            if (it.care) check($sformatf("cycle%0d", ncyc), 32'(a), 32'(it.e));
            ncyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs each state must show, straight from the behaviour table.
    function automatic outs_t rec(input logic [3:0] st);
        outs_t e;
        e = '0;
        e.state_dbg = st;
        case (st)
            S_FETCH:    begin e.mem_read = 1; e.alu_src_b = 2'b01; end
            S_DECODE:   begin e.alu_src_b = 2'b10; e.aluout_write = 1; end
            S_EXEC_R:   begin e.alu_src_a = 1; e.aluout_write = 1; end
            S_EXEC_I,
            S_MEM_ADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluout_write = 1; end
            S_MEM_RD:   begin e.mem_read = 1; e.iord = 1; end
            S_MEM_WR:   begin e.mem_write = 1; e.iord = 1; end
            S_WB_ALU:   e.reg_write = 1;
            S_WB_MEM:   begin e.reg_write = 1; e.wb_src = 1; end
            S_BRANCH:   begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 1; end
            S_JUMP:     begin e.pc_write = 1; e.pc_src = 1; end
            S_HALT:     e.halted = 1;
            default:    ;
        endcase
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic rdy, input logic zf, input logic care, input outs_t e);
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        zero_flag = zf;
        instr     = cur_ir;
        exp_q.push_back({care, e});
    endtask

    task automatic cyc_n(input outs_t e);
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, e);
    endtask

    // A handshake that stalls 'stalls' cycles; the stall that finds the count at the limit times out.
    task automatic mem_phase(input outs_t base, input bit is_fetch, input int stalls, output bit to);
        outs_t e;
        to = 1'b0;
        for (int k = 0; k <= stalls; k++) begin
            if (k == stalls) begin
                e = base;
                if (is_fetch) begin e.ir_write = 1; e.pc_write = 1; end
                cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, e);
                return;
            end
            if (WL > 0 && k == WL) begin
                e = base;
                e.mem_error = 1;
                cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, e);
                to = 1'b1;
                return;
            end
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, base);
        end
    endtask

    task automatic halt_tail();
        repeat (3) cyc_n(rec(S_HALT));
    endtask

    task automatic run_instr(input logic [3:0] op, input int fs, input int ms, input logic zf, output bit hlt);
        outs_t e;
        bit    to;
        bit    legal;
        hlt    = 1'b0;
        to     = 1'b0;
        legal  = (op <= 4'h7) || (op == 4'hF);
        cur_ir = {op, 12'($urandom)};
        mem_phase(rec(S_FETCH), 1'b1, fs, to);
        if (!to) begin
            e = rec(S_DECODE);
            e.illegal_op = !legal;
            cyc_n(e);
            if (legal) begin
                case (op)
                    4'h0, 4'h1, 4'h2: begin
                        e = rec(S_EXEC_R);
                        e.alu_op = op[2:0];
                        cyc_n(e);
                        cyc_n(rec(S_WB_ALU));
                    end
                    4'h3: begin cyc_n(rec(S_EXEC_I)); cyc_n(rec(S_WB_ALU)); end
                    4'h4: begin
                        cyc_n(rec(S_MEM_ADDR));
                        mem_phase(rec(S_MEM_RD), 1'b0, ms, to);
                        if (!to) cyc_n(rec(S_WB_MEM));
                    end
                    4'h5: begin
                        cyc_n(rec(S_MEM_ADDR));
                        mem_phase(rec(S_MEM_WR), 1'b0, ms, to);
                    end
                    4'h6: begin
                        e = rec(S_BRANCH);
                        e.pc_write = zf;
                        cyc(1'b1, 1'($urandom_range(0, 1)), zf, 1'b1, e);
                    end
                    4'h7:    cyc_n(rec(S_JUMP));
                    default: to = 1'b1;
                endcase
            end
        end
        if (to) begin
            halt_tail();
            hlt = 1'b1;
        end
    endtask

    // Reset cycles must be all-zero; the release cycle itself is not compared.
    task automatic do_reset(input int n);
        repeat (n) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, '0);
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
        after_reset = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic int pick_stall();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 6) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
    endfunction

    initial begin
        bit h;
        logic [3:0] op;
        int fs;

        do_reset(3);

        // ADD, no stalls
        settle(); hist.delete();
        run_instr(4'h0, 0, 0, 1'b0, h);
        settle();
        check("t1_len", 32'(hist.size()), 32'd4);
        check("t1_aluop", 32'(hist[2].alu_op), 32'd0);
        check("t1_regwr", 32'({hist[0].reg_write, hist[1].reg_write, hist[2].reg_write, hist[3].reg_write}), 32'b0001);

        // fetch never answered: four stalls, then the timeout cycle
        hist.delete();
        run_instr(4'h0, 10, 0, 1'b0, h);
        settle();
        check("t4_len", 32'(hist.size()), 32'd8);
        check("t4_err_early", 32'(hist[3].mem_error), 32'd0);
        check("t4_err_pulse", 32'(hist[4].mem_error), 32'd1);
        check("t4_halt", 32'({hist[5].halted, hist[5].mem_error, hist[7].halted}), 32'b101);
        do_reset(2);

        // undefined opcode acts as a NOP
        settle(); hist.delete();
        run_instr(4'h9, 0, 0, 1'b0, h);
        settle();
        check("t5_len", 32'(hist.size()), 32'd2);
        check("t5_illegal", 32'(hist[1].illegal_op), 32'd1);
        check("t5_no_wr", 32'({hist[1].reg_write, hist[1].pc_write}), 32'd0);

        // ready arrives exactly in the limit cycle: handshake wins
        hist.delete();
        run_instr(4'h3, WL, 0, 1'b0, h);
        settle();
        check("tb_len", 32'(hist.size()), 32'(WL + 4));
        check("tb_win", 32'({hist[WL].ir_write, hist[WL].mem_error}), 32'b10);

        // LW with two stalls in MEM_RD
        hist.delete();
        run_instr(4'h4, 0, 2, 1'b0, h);
        settle();
        check("t2_len", 32'(hist.size()), 32'd7);
        check("t2_rd", 32'({hist[3].mem_read, hist[4].mem_read, hist[5].mem_read, hist[6].mem_read}), 32'b1110);
        check("t2_wbsrc", 32'(hist[6].wb_src), 32'd1);

        // BEQ taken and not taken
        hist.delete();
        run_instr(4'h6, 0, 0, 1'b1, h);
        run_instr(4'h6, 0, 0, 1'b0, h);
        settle();
        check("t3_len", 32'(hist.size()), 32'd6);
        check("t3_taken", 32'({hist[2].pc_write, hist[2].pc_src}), 32'b11);
        check("t3_nottaken", 32'({hist[5].pc_write, hist[5].pc_src}), 32'b01);

        // reset asserted while MEM_WR is stalled
        hist.delete();
        cur_ir = {4'h5, 12'h0A5};
        mem_phase(rec(S_FETCH), 1'b1, 0, h);
        cyc_n(rec(S_DECODE));
        cyc_n(rec(S_MEM_ADDR));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, rec(S_MEM_WR));
        do_reset(2);
        run_instr(4'h0, 0, 0, 1'b0, h);
        settle();
        check("t6_before", 32'(hist[3].mem_write), 32'd1);
        check("t6_drop", 32'({hist[4].mem_write, hist[4].iord}), 32'd0);
        check("t6_fetch", 32'(hist[7].state_dbg), 32'(S_FETCH));

        // random instruction stream
        after_reset = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            fs = after_reset ? 0 : pick_stall();
            after_reset = 1'b0;
            run_instr(op, fs, pick_stall(), 1'($urandom_range(0, 1)), h);
            if (h) do_reset(int'($urandom_range(1, 3)));
        end

        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
